// File: rtl/crc_encoder.sv
// Bit-serial CRC generator: accepts one message, shifts it MSB-first through an
// LFSR, then presents the codeword {message, crc} on a ready/valid output.
module crc_encoder #(
  parameter int                 MSG_W = 16,
  parameter int                 CRC_W = 16,
  parameter logic [CRC_W-1:0]   POLY  = 16'h1021,
  parameter logic [CRC_W-1:0]   INIT  = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [MSG_W-1:0]         in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [MSG_W+CRC_W-1:0]   out_data,
  output logic [CRC_W-1:0]         out_crc,
  output logic                     busy
);

  localparam int              CNT_W   = (MSG_W > 1) ? $clog2(MSG_W) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MSG_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] bit_cnt;
  logic [MSG_W-1:0] msg_reg;
  logic [CRC_W-1:0] lfsr;
  logic [CRC_W-1:0] lfsr_next;
  logic             fb;
  logic             accept;

  // in_ready is gated by rst so nothing is offered while reset is held.
  assign in_ready = rst && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
  assign accept   = in_valid && in_ready;
  assign busy     = (state == S_SHIFT);

  // NOTE: pure combinational next-LFSR value; every output is assigned
  // unconditionally, so no latch can be inferred.
  always_comb begin
    fb        = msg_reg[bit_cnt] ^ lfsr[CRC_W-1];
    lfsr_next = {lfsr[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  // NOTE: all state updates use non-blocking assignments so that every
  // register samples values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      msg_reg   <= '0;
      lfsr      <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_crc   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            msg_reg <= in_data;
            lfsr    <= INIT;
            bit_cnt <= CNT_MAX;
            state   <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          lfsr    <= lfsr_next;
          bit_cnt <= bit_cnt - 1'b1;
          if (bit_cnt == '0) begin
            out_data  <= {msg_reg, lfsr_next};
            out_crc   <= lfsr_next;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Output handshake and next accept may share this edge.
            if (accept) begin
              msg_reg <= in_data;
              lfsr    <= INIT;
              bit_cnt <= CNT_MAX;
              state   <= S_SHIFT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_encoder.sv
// Directed self-checking bench for crc_encoder (CRC-16, poly 0x1021, init 0).
module tb_crc_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [15:0] out_crc;
  logic        busy;

  int compared   = 0;
  int mismatched = 0;

  crc_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_crc   (out_crc),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Advance one clock and settle just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Independent model of the downstream checker: remainder of a codeword.
  function automatic logic [15:0] chk_rem(input logic [31:0] w);
    logic [15:0] r;
    logic        f;
    r = 16'h0000;
    for (int i = 31; i >= 0; i--) begin
      f = w[i] ^ r[15];
      r = {r[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
    end
    return r;
  endfunction

  // Accept msg, replace in_data with alt after the accept edge, expect exp.
  task automatic run_msg(input string tag, input logic [15:0] msg, input logic [15:0] alt,
                         input logic [31:0] exp);
    int n;
    in_valid  = 1'b1;
    in_data   = msg;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    in_data  = alt;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'd16);
    check({tag, "_data"}, 64'(out_data), 64'(exp));
    check({tag, "_crc"}, 64'(out_crc), 64'(exp[15:0]));
    check({tag, "_rem"}, 64'(chk_rem(out_data)), 64'd0);
    step();
    check({tag, "_drop"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0000;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_crc", 64'(out_crc), 64'd0);
    step();
    step();
    rst = 1'b1;
    #1;
    check("rel_in_ready", 64'(in_ready), 64'd1);

    // Basic vectors and linearity.
    run_msg("m4841", 16'h4841, 16'h4841, 32'h4841DC80);
    run_msg("m0001", 16'h0001, 16'h0001, 32'h00011021);
    run_msg("m0002", 16'h0002, 16'h0002, 32'h00022042);
    run_msg("m0003", 16'h0003, 16'h0003, 32'h00033063);
    run_msg("m0000", 16'h0000, 16'h0000, 32'h00000000);

    // Input change after accept is ignored.
    run_msg("chg", 16'h0001, 16'hFFFF, 32'h00011021);

    // Backpressure: hold for 5 cycles while a new request is offered.
    in_valid  = 1'b1;
    in_data   = 16'h0002;
    out_ready = 1'b0;
    step();
    in_data = 16'hFFFF;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("bp_latency", 64'(n), 64'd16);
    for (int i = 0; i < 5; i++) begin
      check("bp_in_ready", 64'(in_ready), 64'd0);
      step();
      check("bp_valid", 64'(out_valid), 64'd1);
      check("bp_data", 64'(out_data), 64'h00022042);
      check("bp_busy", 64'(busy), 64'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_valid", 64'(out_valid), 64'd0);
    check("bp_release_idle", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | out_valid | busy;
    end
    check("bp_single_xfer", 64'(seen), 64'd0);

    // Back-to-back: continuous in_valid.
    in_valid  = 1'b1;
    in_data   = 16'h0001;
    out_ready = 1'b1;
    step();
    in_data = 16'h4841;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("b2b_latency", 64'(n), 64'd16);
    check("b2b_first", 64'(out_data), 64'h00011021);
    check("b2b_overlap_ready", 64'(in_ready), 64'd1);
    step();
    check("b2b_reaccept", 64'(busy), 64'd1);
    check("b2b_valid_drop", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check("b2b_spacing", 64'(n), 64'd17);
    check("b2b_second", 64'(out_data), 64'h4841DC80);
    step();
    check("b2b_end", 64'(out_valid), 64'd0);

    // Reset mid-SHIFT aborts the word.
    in_valid = 1'b1;
    in_data  = 16'hA5C3;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    check("mid_busy_before", 64'(busy), 64'd1);
    rst = 1'b0;
    #1;
    check("mid_busy", 64'(busy), 64'd0);
    check("mid_valid", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    step();
    step();
    rst = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen = seen | out_valid;
    end
    check("mid_no_output", 64'(seen), 64'd0);
    check("mid_out_data", 64'(out_data), 64'd0);
    run_msg("post_rst", 16'h4841, 16'h4841, 32'h4841DC80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/crc_encoder.md
Name: crc_encoder

Overview:
- Serial CRC-16 generator: accepts a MSG_W-bit message, computes CRC = (M(x)·x^CRC_W) mod G(x) with a bit-serial LFSR, and emits the codeword {message, crc}.
- Sits directly upstream of the CRC checker stage. Every codeword it produces leaves a zero remainder when shifted MSB-first through the checker's LFSR.
- Uses ready/valid handshakes on both sides.

Parameters:
- MSG_W, 16, message width in bits; codeword width is MSG_W+CRC_W.
- CRC_W, 16, CRC width.
- POLY, 16'h1021, generator polynomial without the implicit x^16 term (x^16+x^12+x^5+1).
- INIT, 16'h0000, LFSR seed loaded at each message accept.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- in_valid  in  1  message on in_data is valid.
- in_ready  out  1  block can accept a message this cycle.
- in_data  in  MSG_W  message, MSB is transmitted first.
- out_valid  out  1  codeword on out_data is valid.
- out_ready  in  1  downstream accepts the codeword.
- out_data  out  MSG_W+CRC_W  codeword {msg, crc}; msg occupies the upper MSG_W bits.
- out_crc  out  CRC_W  CRC field alone (equal to out_data[CRC_W-1:0]).
- busy  out  1  high while in SHIFT.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; out_valid=0, out_data=0, out_crc=0, busy=0; internal counter, message register and LFSR are cleared.
  - in_ready is 0 while rst=0, and 1 from the first cycle after rst deasserts.
  - A reset mid-SHIFT or mid-DONE aborts the word; no partial output is ever flagged valid.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge where in_valid&&in_ready: latch in_data into msg_reg, load LFSR=INIT, set bit_cnt=MSG_W-1, go to SHIFT.
- SHIFT:
  - in_ready=0, busy=1.
  - Each edge consumes one message bit b = msg_reg[bit_cnt], MSB first:
    - fb = b ^ lfsr[CRC_W-1];
    - lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - bit_cnt decrements each edge. After the bit_cnt==0 edge (the MSG_W-th SHIFT edge):
    - out_data <= {msg_reg, lfsr_next}; out_crc <= lfsr_next;
    - out_valid <= 1; go to DONE.
- Latency: out_valid is high starting exactly MSG_W cycles after the accept edge (16 for the defaults).
- DONE:
  - out_valid=1. out_data and out_crc stay stable until the edge where out_ready=1.
  - in_ready = out_ready (pass-through, so back-to-back operation is possible).
  - Edge with out_ready=1 and in_valid=0: out_valid <= 0, go to IDLE.
  - Edge with out_ready=1 and in_valid=1: output handshake and a new input accept happen on the same edge; go to SHIFT with the new message, and out_valid <= 0.
  - Edge with out_ready=0: hold; new input is not accepted.
- Throughput: one codeword per MSG_W+1 cycles when downstream is always ready.
- in_data is sampled only at the accept edge; changes afterwards are ignored.
- Arithmetic: no bit reflection, no final XOR, all widths exact.
  - msg=0 with INIT=0 gives crc=0.
  - The CRC is linear in the message when INIT=0.

Test Plan:
- Reset release, in_valid=1, in_data=16'h4841, out_ready=1 -> exactly 16 cycles later out_valid=1 with out_data=32'h4841DC80 and out_crc=16'hDC80. Feeding that word MSB-first into the checker LFSR leaves remainder 0.
- in_data=16'h0001 -> out_data=32'h00011021; in_data=16'h0002 -> 32'h00022042; in_data=16'h0003 -> 32'h00033063 (linearity check); in_data=16'h0000 -> 32'h00000000.
- Backpressure: out_ready=0 for 5 cycles after out_valid rises -> out_valid and out_data are held constant, in_ready=0, and a new in_valid pulse is not accepted. Raising out_ready completes exactly one transfer.
- Back-to-back: in_valid=1 continuously with messages 16'h0001 then 16'h4841, out_ready=1 -> outputs 32'h00011021 then 32'h4841DC80, spaced exactly 17 cycles apart.
- Reset mid-SHIFT (rst=0 at shift cycle 8): out_valid and busy drop immediately (asynchronous) and no output is produced. After release, a fresh 16'h4841 gives a correct 32'h4841DC80, with no residue from the aborted word.
- Input change after accept: in_data changes from 16'h0001 to 16'hFFFF one cycle after the accept edge -> output is still 32'h00011021.
